wr_ctrl_gray: RTL and testbench

WR_CTRL_GRAY -- requirements
Module: wr_ctrl_gray

---
 rtl/cdc_lib_pkg.sv | 26 ++
 rtl/sync_bus_ff.sv | 31 +++
 rtl/wr_ctrl_gray.sv | 104 ++++++++++
 tb/tb_wr_ctrl_gray.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cdc_lib_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : cdc_lib                                                       |
// | Description: Gray/binary pointer conversions shared by FIFO controllers.   |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
package cdc_lib;

   // Functions work on a fixed wide word; callers zero-extend and take low bits.
   localparam int CDC_FN_W = 32;

   function automatic logic [CDC_FN_W-1:0] bin2gray(input logic [CDC_FN_W-1:0] i_bin);
      return i_bin ^ (i_bin >> 1);
   endfunction

   function automatic logic [CDC_FN_W-1:0] gray2bin(input logic [CDC_FN_W-1:0] i_gray);
      logic [CDC_FN_W-1:0] v_bin;
      v_bin[CDC_FN_W-1] = i_gray[CDC_FN_W-1];
      for (int i = CDC_FN_W-2; i >= 0; i--) begin
         v_bin[i] = v_bin[i+1] ^ i_gray[i];
      end
      return v_bin;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_bus_ff.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : sync_bus_ff                                                   |
// | Description: Multi-stage flop synchronizer for a Gray-coded bus.           |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module sync_bus_ff #(
   parameter int P_WIDTH  = 5,
   parameter int P_STAGES = 2
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [P_WIDTH-1:0] i_d,
   output logic [P_WIDTH-1:0] o_q
);

   // Stage 0 samples the foreign-domain bus; stage P_STAGES-1 is the safe copy.
   logic [P_STAGES-1:0][P_WIDTH-1:0] r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[P_STAGES-2:0], i_d};
      end
   end

   assign o_q = r_sync[P_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/wr_ctrl_gray.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : wr_ctrl_gray                                                  |
// | Description: Async FIFO write-side controller with Gray pointer exchange.  |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module wr_ctrl_gray
   import cdc_lib::*;
#(
   parameter int P_ADDR_WIDTH  = 4,
   parameter int P_SYNC_STAGES = 2
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_inc,
   input  logic [P_ADDR_WIDTH:0]   i_rd_ptr_gray,
   input  logic [P_ADDR_WIDTH:0]   i_afull_thresh,
   input  logic                    i_ovf_clr,
   output logic                    o_wr_en,
   output logic [P_ADDR_WIDTH-1:0] o_wr_addr,
   output logic [P_ADDR_WIDTH:0]   o_wr_ptr_gray,
   output logic                    o_full,
   output logic                    o_afull,
   output logic [P_ADDR_WIDTH:0]   o_level,
   output logic                    o_overflow
);

   localparam int PW = P_ADDR_WIDTH + 1;

   logic [PW-1:0]       r_wbin;
   logic [PW-1:0]       r_wgray;
   logic [PW-1:0]       r_level;
   logic                r_full;
   logic                r_afull;
   logic                r_ovf;

   logic                w_wr_en;
   logic [PW-1:0]       w_wbin_next;
   logic [PW-1:0]       w_wgray_next;
   logic [PW-1:0]       w_rgray_s;
   logic [PW-1:0]       w_rbin_s;
   logic [PW-1:0]       w_full_ptr;
   logic [PW-1:0]       w_level_next;
   logic [CDC_FN_W-1:0] w_gray_fn;
   logic [CDC_FN_W-1:0] w_bin_fn;
   logic                w_unused_fn_hi;

   assign w_wr_en     = i_inc & ~r_full;
   assign w_wbin_next = r_wbin + {{(PW-1){1'b0}}, w_wr_en};

   assign w_gray_fn    = bin2gray(CDC_FN_W'(w_wbin_next));
   assign w_wgray_next = w_gray_fn[PW-1:0];

   sync_bus_ff #(
      .P_WIDTH  (PW),
      .P_STAGES (P_SYNC_STAGES)
   ) u_rptr_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_rd_ptr_gray),
      .o_q     (w_rgray_s)
   );

   assign w_bin_fn       = gray2bin(CDC_FN_W'(w_rgray_s));
   assign w_rbin_s       = w_bin_fn[PW-1:0];
   assign w_unused_fn_hi = ^{w_gray_fn[CDC_FN_W-1:PW], w_bin_fn[CDC_FN_W-1:PW]};

   // Full when the next write pointer has lapped the read pointer exactly once.
   assign w_full_ptr   = {~w_rgray_s[PW-1:PW-2], w_rgray_s[PW-3:0]};
   assign w_level_next = w_wbin_next - w_rbin_s;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wbin  <= '0;
         r_wgray <= '0;
         r_full  <= 1'b0;
         r_level <= '0;
         r_afull <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_wbin  <= w_wbin_next;
         r_wgray <= w_wgray_next;
         r_full  <= (w_wgray_next == w_full_ptr);
         r_level <= w_level_next;
         r_afull <= (w_level_next >= i_afull_thresh);
         // A rejected write in the same cycle as a clear keeps the flag set.
         if (i_inc && r_full) begin
            r_ovf <= 1'b1;
         end else if (i_ovf_clr) begin
            r_ovf <= 1'b0;
         end
      end
   end

   assign o_wr_en       = w_wr_en;
   assign o_wr_addr     = r_wbin[P_ADDR_WIDTH-1:0];
   assign o_wr_ptr_gray = r_wgray;
   assign o_full        = r_full;
   assign o_afull       = r_afull;
   assign o_level       = r_level;
   assign o_overflow    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_wr_ctrl_gray.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_wr_ctrl_gray                                               |
// | Description: Directed vector bench for wr_ctrl_gray (depth 16, 2 stages).  |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module tb_wr_ctrl_gray;

   logic       i_clk;
   logic       i_rst_n;
   logic       i_inc;
   logic [4:0] i_rd_ptr_gray;
   logic [4:0] i_afull_thresh;
   logic       i_ovf_clr;
   logic       o_wr_en;
   logic [3:0] o_wr_addr;
   logic [4:0] o_wr_ptr_gray;
   logic       o_full;
   logic       o_afull;
   logic [4:0] o_level;
   logic       o_overflow;

   int n_checks = 0;
   int n_pass   = 0;

   wr_ctrl_gray #(
      .P_ADDR_WIDTH  (4),
      .P_SYNC_STAGES (2)
   ) dut (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_inc          (i_inc),
      .i_rd_ptr_gray  (i_rd_ptr_gray),
      .i_afull_thresh (i_afull_thresh),
      .i_ovf_clr      (i_ovf_clr),
      .o_wr_en        (o_wr_en),
      .o_wr_addr      (o_wr_addr),
      .o_wr_ptr_gray  (o_wr_ptr_gray),
      .o_full         (o_full),
      .o_afull        (o_afull),
      .o_level        (o_level),
      .o_overflow     (o_overflow)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   typedef struct {
      logic       inc;
      logic       clr;
      logic [4:0] rd;
      logic       wr_en;
      logic [3:0] addr;
      logic [4:0] level;
      logic       full;
      logic       afull;
      logic       ovf;
   } vec_t;

   vec_t vecs [29];

   function automatic vec_t mk(input logic inc, input logic clr, input logic [4:0] rd,
                               input logic we, input logic [3:0] a, input logic [4:0] lv,
                               input logic f, input logic af, input logic ov);
      vec_t v;
      v.inc = inc; v.clr = clr; v.rd = rd; v.wr_en = we; v.addr = a;
      v.level = lv; v.full = f; v.afull = af; v.ovf = ov;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      i_rst_n = 1'b0; i_inc = 1'b0; i_ovf_clr = 1'b0; i_rd_ptr_gray = '0;
      #1;
      tick(); tick();
      i_rst_n = 1'b1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_full"},  32'(o_full),        32'd0);
      chk({tag, "_afull"}, 32'(o_afull),       32'd0);
      chk({tag, "_level"}, 32'(o_level),       32'd0);
      chk({tag, "_ovf"},   32'(o_overflow),    32'd0);
      chk({tag, "_gray"},  32'(o_wr_ptr_gray), 32'd0);
      chk({tag, "_addr"},  32'(o_wr_addr),     32'd0);
   endtask

   initial begin
      logic [4:0] exp_wbin;
      logic [4:0] rb;
      logic [4:0] prev_g;

      // Fill 16 with read pointer at 0; threshold 12.
      for (int k = 0; k < 16; k++)
         vecs[k] = mk(1'b1, 1'b0, 5'd0, 1'b1, 4'(k), 5'(k+1), (k == 15), (k >= 11), 1'b0);
      vecs[16] = mk(1'b1, 1'b0, 5'b00000, 1'b0, 4'd0, 5'd16, 1'b1, 1'b1, 1'b1);
      vecs[17] = mk(1'b1, 1'b1, 5'b00000, 1'b0, 4'd0, 5'd16, 1'b1, 1'b1, 1'b1);
      vecs[18] = mk(1'b0, 1'b1, 5'b00001, 1'b0, 4'd0, 5'd16, 1'b1, 1'b1, 1'b0);
      vecs[19] = mk(1'b0, 1'b0, 5'b00001, 1'b0, 4'd0, 5'd16, 1'b1, 1'b1, 1'b0);
      vecs[20] = mk(1'b0, 1'b0, 5'b00001, 1'b0, 4'd0, 5'd15, 1'b0, 1'b1, 1'b0);
      vecs[21] = mk(1'b1, 1'b0, 5'b00001, 1'b1, 4'd0, 5'd16, 1'b1, 1'b1, 1'b0);
      vecs[22] = mk(1'b0, 1'b0, 5'b00011, 1'b0, 4'd1, 5'd16, 1'b1, 1'b1, 1'b0);
      vecs[23] = mk(1'b0, 1'b0, 5'b00010, 1'b0, 4'd1, 5'd16, 1'b1, 1'b1, 1'b0);
      vecs[24] = mk(1'b0, 1'b0, 5'b00110, 1'b0, 4'd1, 5'd15, 1'b0, 1'b1, 1'b0);
      vecs[25] = mk(1'b0, 1'b0, 5'b00111, 1'b0, 4'd1, 5'd14, 1'b0, 1'b1, 1'b0);
      vecs[26] = mk(1'b0, 1'b0, 5'b00101, 1'b0, 4'd1, 5'd13, 1'b0, 1'b1, 1'b0);
      vecs[27] = mk(1'b0, 1'b0, 5'b00101, 1'b0, 4'd1, 5'd12, 1'b0, 1'b1, 1'b0);
      vecs[28] = mk(1'b0, 1'b0, 5'b00101, 1'b0, 4'd1, 5'd11, 1'b0, 1'b0, 1'b0);

      // Reset asserted at time zero: outputs must be clear before any edge.
      i_rst_n = 1'b0; i_inc = 1'b0; i_ovf_clr = 1'b0;
      i_rd_ptr_gray = '0; i_afull_thresh = 5'd12;
      #3;
      chk_reset_outputs("por");
      tick(); tick();
      i_rst_n = 1'b1;

      for (int v = 0; v < 29; v++) begin
         i_inc = vecs[v].inc; i_ovf_clr = vecs[v].clr; i_rd_ptr_gray = vecs[v].rd;
         #1;
         chk($sformatf("v%0d_wr_en", v), 32'(o_wr_en),   32'(vecs[v].wr_en));
         chk($sformatf("v%0d_addr", v),  32'(o_wr_addr), 32'(vecs[v].addr));
         tick();
         chk($sformatf("v%0d_level", v), 32'(o_level),    32'(vecs[v].level));
         chk($sformatf("v%0d_full", v),  32'(o_full),     32'(vecs[v].full));
         chk($sformatf("v%0d_afull", v), 32'(o_afull),    32'(vecs[v].afull));
         chk($sformatf("v%0d_ovf", v),   32'(o_overflow), 32'(vecs[v].ovf));
      end

      // Wrap: prefill 6, then write and read every cycle across 31 -> 0.
      do_reset();
      for (int k = 0; k < 6; k++) begin
         i_inc = 1'b1;
         tick();
      end
      chk("wrap_prefill_level", 32'(o_level), 32'd6);
      exp_wbin = 5'd6;
      prev_g   = 5'b00101;
      chk("wrap_prefill_gray", 32'(o_wr_ptr_gray), 32'(prev_g));
      for (int j = 0; j < 40; j++) begin
         i_inc = 1'b1;
         rb = 5'(j + 1);
         i_rd_ptr_gray = rb ^ (rb >> 1);
         #1;
         chk($sformatf("wrap%0d_wr_en", j), 32'(o_wr_en), 32'd1);
         tick();
         exp_wbin = exp_wbin + 5'd1;
         chk($sformatf("wrap%0d_gray", j), 32'(o_wr_ptr_gray), 32'(exp_wbin ^ (exp_wbin >> 1)));
         chk($sformatf("wrap%0d_hd", j), 32'($countones(o_wr_ptr_gray ^ prev_g)), 32'd1);
         chk($sformatf("wrap%0d_full", j), 32'(o_full), 32'd0);
         chk($sformatf("wrap%0d_level", j), 32'(o_level), (j == 0) ? 32'd7 : 32'd8);
         prev_g = o_wr_ptr_gray;
      end

      // Asynchronous reset mid-burst at level 9.
      do_reset();
      for (int k = 0; k < 9; k++) begin
         i_inc = 1'b1;
         tick();
      end
      chk("burst_level9", 32'(o_level), 32'd9);
      #2;
      i_rst_n = 1'b0;
      #1;
      chk_reset_outputs("async");
      i_inc = 1'b0;
      tick(); tick();
      i_rst_n = 1'b1;
      i_inc = 1'b1;
      #1;
      chk("post_rst_addr", 32'(o_wr_addr), 32'd0);
      chk("post_rst_wr_en", 32'(o_wr_en), 32'd1);
      tick();
      chk("post_rst_level", 32'(o_level), 32'd1);
      chk("post_rst_gray", 32'(o_wr_ptr_gray), 32'd1);

      // Threshold 0 keeps almost-full asserted even when nearly empty.
      i_inc = 1'b0;
      i_afull_thresh = 5'd0;
      tick();
      chk("thresh0_afull", 32'(o_afull), 32'd1);
      i_afull_thresh = 5'd2;
      tick();
      chk("thresh2_afull", 32'(o_afull), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
